// File: rtl/rr_req_gnt_arbiter.sv
// Round-robin req/gnt arbiter: registered one-hot grant, held until release,
// revoked after MAX_HOLD cycles when another requester is waiting.
module rr_req_gnt_arbiter #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    output logic [NUM_REQ-1:0]         gnt,
    output logic                       gnt_vld,
    output logic [$clog2(NUM_REQ)-1:0] gnt_id,
    output logic                       preempt
);

    localparam int unsigned IW  = $clog2(NUM_REQ);
    localparam int unsigned HCW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam bit          PREEMPT_EN = (MAX_HOLD != 0);
    localparam logic [HCW-1:0] HOLD_SAT = HCW'(MAX_HOLD);
    localparam logic [HCW-1:0] HOLD_LIM = HCW'((MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic             gnt_vld_q, gnt_vld_d;
    logic [IW-1:0]    gnt_id_q, gnt_id_d;
    logic             preempt_q, preempt_d;
    logic [HCW-1:0]   hold_cnt_q, hold_cnt_d;
    logic [IW-1:0]    ptr_q, ptr_d;

    logic [NUM_REQ-1:0] cand_c;
    logic             pick_vld_c;
    logic [IW-1:0]    pick_idx_c;
    logic             take_c;

    // The current owner is never a candidate: covers both release and preemption.
    assign cand_c = req & ~gnt_q;

    // First candidate in order ptr, ptr+1, ... wrapping modulo NUM_REQ.
    always_comb begin
        pick_vld_c = 1'b0;
        pick_idx_c = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!pick_vld_c && cand_c[IW'((32'(ptr_q) + k) % NUM_REQ)]) begin
                pick_vld_c = 1'b1;
                pick_idx_c = IW'((32'(ptr_q) + k) % NUM_REQ);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        gnt_vld_d  = gnt_vld_q;
        gnt_id_d   = gnt_id_q;
        preempt_d  = 1'b0;
        hold_cnt_d = hold_cnt_q;
        ptr_d      = ptr_q;
        take_c     = 1'b0;

        case (state_q)
            IDLE: begin
                take_c = pick_vld_c;
            end
            GRANT: begin
                if (!req[gnt_id_q]) begin
                    // Release wins over expiry; hand over with no idle bubble.
                    if (pick_vld_c) begin
                        take_c = 1'b1;
                    end else begin
                        state_d    = IDLE;
                        gnt_d      = '0;
                        gnt_vld_d  = 1'b0;
                        gnt_id_d   = '0;
                        hold_cnt_d = '0;
                    end
                end else if (PREEMPT_EN && (hold_cnt_q >= HOLD_LIM) && pick_vld_c) begin
                    take_c    = 1'b1;
                    preempt_d = 1'b1;
                end else if (hold_cnt_q < HOLD_SAT) begin
                    hold_cnt_d = hold_cnt_q + HCW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (take_c) begin
            state_d    = GRANT;
            gnt_d      = NUM_REQ'(1) << pick_idx_c;
            gnt_vld_d  = 1'b1;
            gnt_id_d   = pick_idx_c;
            hold_cnt_d = '0;
            ptr_d      = IW'((32'(pick_idx_c) + 32'd1) % NUM_REQ);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            gnt_vld_q  <= 1'b0;
            gnt_id_q   <= '0;
            preempt_q  <= 1'b0;
            hold_cnt_q <= '0;
            ptr_q      <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            gnt_vld_q  <= gnt_vld_d;
            gnt_id_q   <= gnt_id_d;
            preempt_q  <= preempt_d;
            hold_cnt_q <= hold_cnt_d;
            ptr_q      <= ptr_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_vld = gnt_vld_q;
    assign gnt_id  = gnt_id_q;
    assign preempt = preempt_q;

`ifndef SYNTHESIS
    // Handshake invariants and covers for the interesting transitions.
    a_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt_q));
    a_vld: assert property (@(posedge clk) disable iff (rst) gnt_vld_q == (|gnt_q));
    a_id: assert property (@(posedge clk) disable iff (rst) gnt_vld_q |-> gnt_q[gnt_id_q]);
    a_id0: assert property (@(posedge clk) disable iff (rst) !gnt_vld_q |-> (gnt_id_q == '0));
    a_release: assert property (@(posedge clk) disable iff (rst)
        (|(gnt_q & ~req)) |=> ((gnt_q & $past(gnt_q & ~req)) == '0));
    a_new_gnt: assert property (@(posedge clk) disable iff (rst)
        ((gnt_q & ~$past(gnt_q) & ~$past(req)) == '0));
    a_preempt: assert property (@(posedge clk) disable iff (rst)
        preempt_q |-> (gnt_vld_q && (gnt_id_q != $past(gnt_id_q))));
    c_preempt: cover property (@(posedge clk) disable iff (rst) preempt_q);
    c_b2b: cover property (@(posedge clk) disable iff (rst)
        gnt_vld_q && $past(gnt_vld_q) && (gnt_id_q != $past(gnt_id_q)) && !preempt_q);
`endif

endmodule

// File: tb/tb_rr_req_gnt_arbiter.sv
// Directed table-driven bench for rr_req_gnt_arbiter (NUM_REQ=4; MAX_HOLD=8 and 0).
module tb_rr_req_gnt_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic       gnt_vld;
    logic [1:0] gnt_id;
    logic       preempt;
    logic [3:0] req_z;
    logic [3:0] gnt_z;
    logic       gnt_vld_z;
    logic [1:0] gnt_id_z;
    logic       preempt_z;

    int n_checks;
    int n_fail;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] id;
        logic       pre;
    } vec_t;

    vec_t tbl[$];

    rr_req_gnt_arbiter #(.NUM_REQ(4), .MAX_HOLD(8)) u_dut (
        .clk(clk), .rst(rst), .req(req),
        .gnt(gnt), .gnt_vld(gnt_vld), .gnt_id(gnt_id), .preempt(preempt)
    );

    rr_req_gnt_arbiter #(.NUM_REQ(4), .MAX_HOLD(0)) u_dut_nohold (
        .clk(clk), .rst(rst), .req(req_z),
        .gnt(gnt_z), .gnt_vld(gnt_vld_z), .gnt_id(gnt_id_z), .preempt(preempt_z)
    );

    always #5 clk = ~clk;

    task automatic add(input logic r, input logic [3:0] rq, input logic [3:0] g,
                       input logic [1:0] id, input logic p);
        vec_t v;
        v.rst = r; v.req = rq; v.gnt = g; v.id = id; v.pre = p;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [3:0] ag, input logic av,
                         input logic [1:0] ai, input logic ap,
                         input logic [3:0] eg, input logic [1:0] ei, input logic ep);
        n_checks++;
        if (ag !== eg || av !== (|eg) || ai !== ei || ap !== ep) begin
            n_fail++;
            $display("FAIL %s: got gnt=%b vld=%b id=%0d pre=%b, want gnt=%b vld=%b id=%0d pre=%b",
                     name, ag, av, ai, ap, eg, |eg, ei, ep);
        end
    endtask

    task automatic step(input logic r, input logic [3:0] rq);
        rst = r;
        req = rq;
        @(posedge clk);
        #1;
    endtask

    initial begin
        clk = 1'b0; rst = 1'b1; req = '0; req_z = '0;
        n_checks = 0; n_fail = 0;

        // Single requester: latency 1, drop one cycle after req drops.
        add(1, 4'b0000, 4'b0000, 2'd0, 0);
        add(0, 4'b0001, 4'b0001, 2'd0, 0);
        add(0, 4'b0001, 4'b0001, 2'd0, 0);
        add(0, 4'b0001, 4'b0001, 2'd0, 0);
        add(0, 4'b0000, 4'b0000, 2'd0, 0);
        // All request, each owner drops while granted: 0,1,2,3,0 back to back.
        add(1, 4'b0000, 4'b0000, 2'd0, 0);
        add(0, 4'b1111, 4'b0001, 2'd0, 0);
        add(0, 4'b1110, 4'b0010, 2'd1, 0);
        add(0, 4'b1101, 4'b0100, 2'd2, 0);
        add(0, 4'b1011, 4'b1000, 2'd3, 0);
        add(0, 4'b0111, 4'b0001, 2'd0, 0);
        add(0, 4'b0000, 4'b0000, 2'd0, 0);
        // Pointer wrap on release: owner 2 releases, search 3,0 -> 0.
        add(1, 4'b0000, 4'b0000, 2'd0, 0);
        add(0, 4'b0110, 4'b0010, 2'd1, 0);
        add(0, 4'b0100, 4'b0100, 2'd2, 0);
        add(0, 4'b0011, 4'b0001, 2'd0, 0);
        add(0, 4'b0010, 4'b0010, 2'd1, 0);
        add(0, 4'b0000, 4'b0000, 2'd0, 0);
        // Mid-operation reset drops grant; pointer restarts at 0.
        add(1, 4'b0000, 4'b0000, 2'd0, 0);
        add(0, 4'b0100, 4'b0100, 2'd2, 0);
        add(1, 4'b0100, 4'b0000, 2'd0, 0);
        add(0, 4'b1000, 4'b1000, 2'd3, 0);
        add(0, 4'b0000, 4'b0000, 2'd0, 0);

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].req);
            check($sformatf("vec%0d", i), gnt, gnt_vld, gnt_id, preempt,
                  tbl[i].gnt, tbl[i].id, tbl[i].pre);
        end

        // Preemption: req[2] alone, req[0] joins; gnt[2] edges 1..8, preempt at 9.
        step(1, 4'b0000);
        for (int c = 1; c <= 10; c++) begin
            step(0, (c >= 4) ? 4'b0101 : 4'b0100);
            if (c <= 8)
                check($sformatf("hold_c%0d", c), gnt, gnt_vld, gnt_id, preempt, 4'b0100, 2'd2, 1'b0);
            else
                check($sformatf("pre_c%0d", c), gnt, gnt_vld, gnt_id, preempt, 4'b0001, 2'd0, c == 9);
        end
        // Owner 0 releases; preempted req[2] was re-queued and regains the grant.
        step(0, 4'b0100);
        check("requeue", gnt, gnt_vld, gnt_id, preempt, 4'b0100, 2'd2, 1'b0);
        step(0, 4'b0000);
        check("requeue_rel", gnt, gnt_vld, gnt_id, preempt, 4'b0000, 2'd0, 1'b0);

        // Lone holder is never preempted; a late competitor preempts the saturated holder.
        step(1, 4'b0000);
        for (int c = 1; c <= 30; c++) begin
            step(0, 4'b0010);
            if (c == 1 || c == 8 || c == 9 || c == 30)
                check($sformatf("alone_c%0d", c), gnt, gnt_vld, gnt_id, preempt, 4'b0010, 2'd1, 1'b0);
            else if (preempt !== 1'b0 || gnt !== 4'b0010)
                check($sformatf("alone_c%0d", c), gnt, gnt_vld, gnt_id, preempt, 4'b0010, 2'd1, 1'b0);
        end
        step(0, 4'b1010);
        check("late_pre", gnt, gnt_vld, gnt_id, preempt, 4'b1000, 2'd3, 1'b1);
        step(0, 4'b0000);
        check("late_rel", gnt, gnt_vld, gnt_id, preempt, 4'b0000, 2'd0, 1'b0);

        // MAX_HOLD=0: owner 0 keeps the grant indefinitely.
        step(1, 4'b0000);
        rst = 1'b0;
        req_z = 4'b0011;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            if (c == 1 || c == 9 || c == 20 || preempt_z !== 1'b0 || gnt_z !== 4'b0001)
                check($sformatf("nohold_c%0d", c), gnt_z, gnt_vld_z, gnt_id_z, preempt_z,
                      4'b0001, 2'd0, 1'b0);
        end
        req_z = 4'b0010;
        @(posedge clk);
        #1;
        check("nohold_rel", gnt_z, gnt_vld_z, gnt_id_z, preempt_z, 4'b0010, 2'd1, 1'b0);
        req_z = 4'b0000;
        @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
